mem_port_arbiter: RTL

//  Shares one single-ported memory between the instruction fetch unit (port F, read-only) and the

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/mem_arb_timeout_ctr.sv | 29 ++
 rtl/mem_port_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the fetch/data memory port arbiter.
// Optional build macro: MEM_ARB_TIMEOUT_EN (see mem_port_arbiter).
package mem_arb_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_F    = 2'd1;
    localparam logic [1:0] OWN_D    = 2'd2;

    localparam logic [3:0] FULL_MASK = 4'b1111;

endpackage

// File: rtl/mem_arb_timeout_ctr.sv
// BUSY-cycle counter for the arbiter's abort path.
// Only instantiated when MEM_ARB_TIMEOUT_EN is defined.
module mem_arb_timeout_ctr #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic busy,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt;

    assign expired = busy & (cnt == CW'(TIMEOUT_CYC));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= '0;
        end else if (busy & ~expired) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter in front of one single-ported memory.
// MEM_ARB_TIMEOUT_EN adds a BUSY timeout abort with arb_err.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 255
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_request,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_valid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_request,
    input  logic              d_we_re,
    input  logic [3:0]        d_mask,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_request,
    output logic              m_we_re,
    output logic [3:0]        m_mask,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_valid,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              arb_err
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [0:0]    state;
    logic [1:0]    owner;
    logic [SW-1:0] starve_cnt;
    logic          busy;
    logic          starved;
    logic          pick_d;
    logic          pick_f;
    logic          grant;
    logic          tmo;
    logic          done;
    logic          own_f;
    logic          own_d;

    assign busy    = (state == ST_BUSY);
    assign starved = (starve_cnt == SW'(STARVE_MAX));
    assign pick_d  = d_request & ~(f_request & starved);
    assign pick_f  = f_request & ~pick_d;
    assign grant   = ~busy & (pick_d | pick_f);

`ifdef MEM_ARB_TIMEOUT_EN
    logic expired;

    mem_arb_timeout_ctr #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_tmo (
        .clk    (clk),
        .rst    (rst),
        .start  (grant),
        .busy   (busy),
        .expired(expired)
    );

    // A real answer in the expiry cycle wins over the abort.
    assign tmo = expired & ~m_valid;
`else
    assign tmo = 1'b0;
`endif

    assign done      = busy & (m_valid | tmo);
    assign own_f     = (owner == OWN_F);
    assign own_d     = (owner == OWN_D);
    assign m_request = busy;
    assign f_valid   = done & own_f;
    assign d_valid   = done & own_d;
    assign f_rdata   = (busy & m_valid & own_f) ? m_rdata : '0;
    assign d_rdata   = (busy & m_valid & own_d) ? m_rdata : '0;
    assign arb_err   = tmo;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            owner      <= OWN_NONE;
            starve_cnt <= '0;
            m_we_re    <= 1'b0;
            m_mask     <= '0;
            m_addr     <= '0;
            m_wdata    <= '0;
        end else if (grant) begin
            state   <= ST_BUSY;
            owner   <= pick_d ? OWN_D : OWN_F;
            m_we_re <= pick_d & d_we_re;
            m_mask  <= pick_d ? d_mask : FULL_MASK;
            m_addr  <= pick_d ? d_addr : f_addr;
            m_wdata <= pick_d ? d_wdata : '0;
            if (pick_f) begin
                starve_cnt <= '0;
            end else if (f_request & ~starved) begin
                starve_cnt <= starve_cnt + SW'(1);
            end
        end else if (done) begin
            state <= ST_IDLE;
            owner <= OWN_NONE;
        end
    end

endmodule
